// File: rtl/matrix_sequencer.sv
// ----------------------------------------------------------------------------
// matrix_sequencer
//
// Walks a tiled matrix multiply C[n x p] = A[n x m] * B[m x p] using 3x3 tiles.
// For every output tile (i, j) it clears the accumulator, then for each inner
// tile k reads A(i,k) and B(k,j) and accumulates their product. Finally it
// writes the accumulator to C(i,j). Tiles are visited with i outermost, j in
// the middle and k innermost.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   reset    : asynchronous active-high reset, returns the block to IDLE
//   start    : begin a job (only looked at while IDLE)
//   n, m, p  : matrix dimensions, captured when start is accepted
//   row_t    : tile row index for the matrix manager
//   col_t    : tile column index for the matrix manager
//   column   : operand select, 0 = A tile, 1 = B tile
//   rd_en    : read one 3x3 tile this cycle
//   load_a   : capture the manager output into the A tile register
//   load_b   : capture the manager output into the B tile register
//   acc_clr  : clear the 3x3 accumulator
//   mac_en   : accumulate A*B into the accumulator
//   dm_we    : write the accumulator tile to C
//   busy     : a job is in progress (every state except IDLE)
//   done     : one-cycle pulse when the job finishes
// ----------------------------------------------------------------------------
module matrix_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] n,
    input  logic [9:0] m,
    input  logic [9:0] p,
    output logic [8:0] row_t,
    output logic [8:0] col_t,
    output logic       column,
    output logic       rd_en,
    output logic       load_a,
    output logic       load_b,
    output logic       acc_clr,
    output logic       mac_en,
    output logic       dm_we,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RDA,
        RDB,
        MAC,
        WR,
        DONE
    } state_t;

    state_t     state_reg;
    logic [8:0] i_reg;
    logic [8:0] j_reg;
    logic [8:0] k_reg;
    logic [9:0] n_reg;
    logic [9:0] m_reg;
    logic [9:0] p_reg;

    // Tile counts are ceil(dim/3). The +2 is done in 11 bits so that 1022 and
    // 1023 do not wrap; the largest quotient (341) fits comfortably in 9 bits.
    logic [8:0] rt;
    logic [8:0] kt;
    logic [8:0] ct;

    assign rt = 9'(({1'b0, n_reg} + 11'd2) / 11'd3);
    assign kt = 9'(({1'b0, m_reg} + 11'd2) / 11'd3);
    assign ct = 9'(({1'b0, p_reg} + 11'd2) / 11'd3);

    // Last-index values. Only used while a job with non-zero dimensions is
    // running, so every count is at least 1 and the subtraction cannot wrap.
    logic [8:0] rt_last;
    logic [8:0] kt_last;
    logic [8:0] ct_last;

    assign rt_last = rt - 9'd1;
    assign kt_last = kt - 9'd1;
    assign ct_last = ct - 9'd1;

    logic any_zero;
    assign any_zero = (n == 10'd0) || (m == 10'd0) || (p == 10'd0);

    // ------------------------------------------------------------------------
    // State, index and dimension registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            i_reg     <= 9'd0;
            j_reg     <= 9'd0;
            k_reg     <= 9'd0;
            n_reg     <= 10'd0;
            m_reg     <= 10'd0;
            p_reg     <= 10'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_reg     <= n;
                        m_reg     <= m;
                        p_reg     <= p;
                        i_reg     <= 9'd0;
                        j_reg     <= 9'd0;
                        k_reg     <= 9'd0;
                        state_reg <= any_zero ? DONE : CLR;
                    end
                end
                CLR: state_reg <= RDA;
                RDA: state_reg <= RDB;
                RDB: state_reg <= MAC;
                MAC: begin
                    if (k_reg < kt_last) begin
                        k_reg     <= k_reg + 9'd1;
                        state_reg <= RDA;
                    end else begin
                        state_reg <= WR;
                    end
                end
                WR: begin
                    k_reg <= 9'd0;
                    if (j_reg < ct_last) begin
                        j_reg     <= j_reg + 9'd1;
                        state_reg <= CLR;
                    end else if (i_reg < rt_last) begin
                        j_reg     <= 9'd0;
                        i_reg     <= i_reg + 9'd1;
                        state_reg <= CLR;
                    end else begin
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode: depends only on registered state and indices, so
    // an asynchronous reset drives every output to 0 immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        row_t   = 9'd0;
        col_t   = 9'd0;
        column  = 1'b0;
        rd_en   = 1'b0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        acc_clr = 1'b0;
        mac_en  = 1'b0;
        dm_we   = 1'b0;
        busy    = (state_reg != IDLE);
        done    = 1'b0;
        case (state_reg)
            CLR: acc_clr = 1'b1;
            RDA: begin
                rd_en  = 1'b1;
                load_a = 1'b1;
                row_t  = i_reg;
                col_t  = k_reg;
            end
            RDB: begin
                rd_en  = 1'b1;
                load_b = 1'b1;
                column = 1'b1;
                row_t  = k_reg;
                col_t  = j_reg;
            end
            MAC: mac_en = 1'b1;
            WR: begin
                dm_we = 1'b1;
                row_t = i_reg;
                col_t = j_reg;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matrix_sequencer.sv
// ----------------------------------------------------------------------------
// tb_matrix_sequencer
//
// Directed bench for matrix_sequencer. Each scenario task starts a job,
// records one sample per cycle (taken on the falling edge) and compares the
// recorded control word and tile indices against hand-derived values.
// Control word bit order:
//   [8] acc_clr [7] rd_en [6] load_a [5] load_b [4] column
//   [3] mac_en  [2] dm_we [1] busy   [0] done
// ----------------------------------------------------------------------------
module tb_matrix_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] n_in;
    logic [9:0] m_in;
    logic [9:0] p_in;
    logic [8:0] row_t;
    logic [8:0] col_t;
    logic       column;
    logic       rd_en;
    logic       load_a;
    logic       load_b;
    logic       acc_clr;
    logic       mac_en;
    logic       dm_we;
    logic       busy;
    logic       done;

    matrix_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .n      (n_in),
        .m      (m_in),
        .p      (p_in),
        .row_t  (row_t),
        .col_t  (col_t),
        .column (column),
        .rd_en  (rd_en),
        .load_a (load_a),
        .load_b (load_b),
        .acc_clr(acc_clr),
        .mac_en (mac_en),
        .dm_we  (dm_we),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [8:0] C_IDLE = 9'b000000000;
    localparam logic [8:0] C_CLR  = 9'b100000010;
    localparam logic [8:0] C_RDA  = 9'b011000010;
    localparam logic [8:0] C_RDB  = 9'b010110010;
    localparam logic [8:0] C_MAC  = 9'b000001010;
    localparam logic [8:0] C_WR   = 9'b000000110;
    localparam logic [8:0] C_DONE = 9'b000000011;

    int passed;
    int total;

    logic [8:0] cap_ctl [64];
    logic [8:0] cap_row [64];
    logic [8:0] cap_col [64];
    int         cap_n;

    function automatic logic [8:0] ctl_now();
        return {acc_clr, rd_en, load_a, load_b, column, mac_en, dm_we, busy, done};
    endfunction

    // Busy cycles before the DONE cycle.
    function automatic int count_busy_pre();
        int c = 0;
        for (int x = 0; x < cap_n; x++)
            if (cap_ctl[x][1] && !cap_ctl[x][0]) c++;
        return c;
    endfunction

    function automatic int count_bit(input int b);
        int c = 0;
        for (int x = 0; x < cap_n; x++)
            if (cap_ctl[x][b]) c++;
        return c;
    endfunction

    task automatic start_job(input logic [9:0] nn, input logic [9:0] mm, input logic [9:0] pp);
        @(negedge clk);
        n_in  = nn;
        m_in  = mm;
        p_in  = pp;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records one sample per cycle until done is seen. With disturb set, start
    // is re-raised and n altered part way through the job.
    task automatic capture(input int budget, input bit disturb);
        bit stop;
        stop  = 1'b0;
        cap_n = 0;
        while (!stop) begin
            @(negedge clk);
            cap_ctl[cap_n] = ctl_now();
            cap_row[cap_n] = row_t;
            cap_col[cap_n] = col_t;
            if (disturb && cap_n == 5) begin
                start = 1'b1;
                n_in  = 10'd3;
            end
            if (disturb && cap_n == 8) start = 1'b0;
            cap_n++;
            if (done) stop = 1'b1;
            else if (cap_n >= budget) begin
                total++;
                $display("FAIL capture_timeout: got no done after %0d cycles, required done within %0d", cap_n, budget);
                stop = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({ctl_now(), row_t, col_t} !== 27'd0)
            $display("FAIL reset_outputs: got %h required 0", {ctl_now(), row_t, col_t});
        else passed++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (ctl_now() !== C_IDLE)
            $display("FAIL reset_idle: got %b required %b", ctl_now(), C_IDLE);
        else passed++;
    endtask

    // n=6 m=3 p=6: four tiles of five cycles each, then DONE.
    task automatic test_six_by_six(input bit disturb);
        int ti[4] = '{0, 0, 1, 1};
        int tj[4] = '{0, 1, 0, 1};
        int b;
        start_job(10'd6, 10'd3, 10'd6);
        capture(60, disturb);
        for (int t = 0; t < 4; t++) begin
            b = 5 * t;
            total++;
            if (cap_ctl[b] !== C_CLR)
                $display("FAIL six_t%0d_clr: got %b required %b", t, cap_ctl[b], C_CLR);
            else passed++;
            total++;
            if ({cap_ctl[b+1], cap_row[b+1], cap_col[b+1]} !== {C_RDA, 9'(ti[t]), 9'd0})
                $display("FAIL six_t%0d_rda: got %b/%0d/%0d required %b/%0d/0", t,
                         cap_ctl[b+1], cap_row[b+1], cap_col[b+1], C_RDA, ti[t]);
            else passed++;
            total++;
            if ({cap_ctl[b+2], cap_row[b+2], cap_col[b+2]} !== {C_RDB, 9'd0, 9'(tj[t])})
                $display("FAIL six_t%0d_rdb: got %b/%0d/%0d required %b/0/%0d", t,
                         cap_ctl[b+2], cap_row[b+2], cap_col[b+2], C_RDB, tj[t]);
            else passed++;
            total++;
            if ({cap_ctl[b+3], cap_row[b+3], cap_col[b+3]} !== {C_MAC, 9'd0, 9'd0})
                $display("FAIL six_t%0d_mac: got %b/%0d/%0d required %b/0/0", t,
                         cap_ctl[b+3], cap_row[b+3], cap_col[b+3], C_MAC);
            else passed++;
            total++;
            if ({cap_ctl[b+4], cap_row[b+4], cap_col[b+4]} !== {C_WR, 9'(ti[t]), 9'(tj[t])})
                $display("FAIL six_t%0d_wr: got %b/%0d/%0d required %b/%0d/%0d", t,
                         cap_ctl[b+4], cap_row[b+4], cap_col[b+4], C_WR, ti[t], tj[t]);
            else passed++;
        end
        total++;
        if (cap_n !== 21 || cap_ctl[20] !== C_DONE)
            $display("FAIL six_done_cycle: got done at sample %0d (%b) required sample 21 (%b)",
                     cap_n, cap_ctl[20], C_DONE);
        else passed++;
        total++;
        if (count_busy_pre() !== 20)
            $display("FAIL six_busy_len: got %0d required 20", count_busy_pre());
        else passed++;
        @(negedge clk);
        total++;
        if (ctl_now() !== C_IDLE)
            $display("FAIL six_idle_after: got %b required %b", ctl_now(), C_IDLE);
        else passed++;
    endtask

    // n=3 m=9 p=3: one output tile, three inner steps.
    task automatic test_inner_k();
        start_job(10'd3, 10'd9, 10'd3);
        capture(60, 1'b0);
        total++;
        if (cap_ctl[0] !== C_CLR)
            $display("FAIL k_clr: got %b required %b", cap_ctl[0], C_CLR);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({cap_ctl[1+3*k], cap_row[1+3*k], cap_col[1+3*k]} !== {C_RDA, 9'd0, 9'(k)})
                $display("FAIL k%0d_rda: got %b/%0d/%0d required %b/0/%0d", k,
                         cap_ctl[1+3*k], cap_row[1+3*k], cap_col[1+3*k], C_RDA, k);
            else passed++;
            total++;
            if ({cap_ctl[2+3*k], cap_row[2+3*k], cap_col[2+3*k]} !== {C_RDB, 9'(k), 9'd0})
                $display("FAIL k%0d_rdb: got %b/%0d/%0d required %b/%0d/0", k,
                         cap_ctl[2+3*k], cap_row[2+3*k], cap_col[2+3*k], C_RDB, k);
            else passed++;
        end
        total++;
        if (count_bit(3) !== 3 || count_bit(2) !== 1)
            $display("FAIL k_pulses: got mac_en=%0d dm_we=%0d required 3 and 1", count_bit(3), count_bit(2));
        else passed++;
        total++;
        if (count_busy_pre() !== 11 || cap_ctl[11] !== C_DONE)
            $display("FAIL k_busy_len: got %0d done_word %b required 11 and %b",
                     count_busy_pre(), cap_ctl[11], C_DONE);
        else passed++;
    endtask

    // n=4 m=1 p=2: two row tiles, one column tile, one inner step.
    task automatic test_rows();
        start_job(10'd4, 10'd1, 10'd2);
        capture(60, 1'b0);
        total++;
        if ({cap_ctl[4], cap_row[4], cap_col[4]} !== {C_WR, 9'd0, 9'd0})
            $display("FAIL rows_wr0: got %b/%0d/%0d required %b/0/0", cap_ctl[4], cap_row[4], cap_col[4], C_WR);
        else passed++;
        total++;
        if ({cap_ctl[6], cap_row[6], cap_col[6]} !== {C_RDA, 9'd1, 9'd0})
            $display("FAIL rows_rda1: got %b/%0d/%0d required %b/1/0", cap_ctl[6], cap_row[6], cap_col[6], C_RDA);
        else passed++;
        total++;
        if ({cap_ctl[9], cap_row[9], cap_col[9]} !== {C_WR, 9'd1, 9'd0})
            $display("FAIL rows_wr1: got %b/%0d/%0d required %b/1/0", cap_ctl[9], cap_row[9], cap_col[9], C_WR);
        else passed++;
        total++;
        if (count_bit(2) !== 2 || cap_n !== 11)
            $display("FAIL rows_count: got dm_we=%0d samples=%0d required 2 and 11", count_bit(2), cap_n);
        else passed++;
    endtask

    // m=0: straight to DONE, no memory traffic.
    task automatic test_zero_dim();
        start_job(10'd5, 10'd0, 10'd5);
        capture(20, 1'b0);
        total++;
        if (cap_n !== 1 || cap_ctl[0] !== C_DONE)
            $display("FAIL zero_done: got samples=%0d word=%b required 1 and %b", cap_n, cap_ctl[0], C_DONE);
        else passed++;
        total++;
        if (count_bit(7) !== 0 || count_bit(2) !== 0 || count_bit(1) !== 1)
            $display("FAIL zero_traffic: got rd_en=%0d dm_we=%0d busy=%0d required 0 0 1",
                     count_bit(7), count_bit(2), count_bit(1));
        else passed++;
        @(negedge clk);
        total++;
        if (ctl_now() !== C_IDLE)
            $display("FAIL zero_idle_after: got %b required %b", ctl_now(), C_IDLE);
        else passed++;
    endtask

    // Reset during the second MAC of the n=3 m=9 p=3 job, then a full rerun.
    task automatic test_reset_mid_job();
        start_job(10'd3, 10'd9, 10'd3);
        repeat (7) @(negedge clk);
        total++;
        if (mac_en !== 1'b1)
            $display("FAIL midreset_at_mac: got mac_en=%b required 1", mac_en);
        else passed++;
        #1 reset = 1'b1;
        #1;
        total++;
        if ({ctl_now(), row_t, col_t} !== 27'd0)
            $display("FAIL midreset_async: got %h required 0", {ctl_now(), row_t, col_t});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        n_in  = 10'd3;
        m_in  = 10'd9;
        p_in  = 10'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        capture(60, 1'b0);
        total++;
        if (cap_ctl[0] !== C_CLR || count_busy_pre() !== 11 || cap_ctl[11] !== C_DONE)
            $display("FAIL midreset_rerun: got first=%b busy=%0d done_word=%b required %b 11 %b",
                     cap_ctl[0], count_busy_pre(), cap_ctl[11], C_CLR, C_DONE);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        n_in   = 10'd0;
        m_in   = 10'd0;
        p_in   = 10'd0;

        test_reset();
        test_six_by_six(1'b0);
        test_inner_k();
        test_rows();
        test_zero_dim();
        test_six_by_six(1'b1);
        test_reset_mid_job();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
